// File: rtl/fetch_bundle_queue.sv
// Fetch bundle FIFO between fetch and aligner, first-word-fall-through; optional stats via FETCH_BUNDLE_QUEUE_STATS_EN.
// Latency: 0 cycles through the empty-queue bypass (PASSTHROUGH=1), otherwise 1 cycle.
// Backpressure: in_busy_o is asserted when full, from registered state only; out_busy_i holds the head.
module fetch_bundle_queue #(
    parameter int FETCH_WORDS = 2,
    parameter int DEPTH       = 8,
    parameter int META_W      = 80,
    parameter int PASSTHROUGH = 1
) (
    input  logic                        core_clock_i,
    input  logic                        core_reset_i,
    input  logic                        flush_i,
    input  logic                        in_vld_i,
    input  logic [32*FETCH_WORDS-1:0]   in_instruction_i,
    input  logic [META_W-1:0]           in_meta_i,
    output logic                        in_busy_o,
    output logic                        out_vld_o,
    output logic [32*FETCH_WORDS-1:0]   out_instruction_o,
    output logic [META_W-1:0]           out_meta_o,
    input  logic                        out_busy_i,
    output logic [$clog2(DEPTH):0]      occupancy_o
`ifdef FETCH_BUNDLE_QUEUE_STATS_EN
    ,
    output logic [31:0]                 full_cycles_o,
    output logic [31:0]                 starve_cycles_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = 32 * FETCH_WORDS;
    localparam int BW = IW + META_W;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [BW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_occ;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_wr;
    logic w_rd;

    always_comb begin
        w_empty   = (r_occ == '0);
        w_full    = (r_occ == FULL_CNT);
        w_bypass  = (PASSTHROUGH != 0) && w_empty;
        w_push    = in_vld_i && !w_full && !flush_i;
        out_vld_o = core_reset_i && !flush_i && (!w_empty || (w_bypass && in_vld_i));
        w_pop     = out_vld_o && !out_busy_i;
        // A bundle consumed straight off the bypass never touches storage.
        w_wr      = w_push && !(w_bypass && w_pop);
        w_rd      = w_pop && !w_empty;
    end

    assign in_busy_o   = w_full;
    assign occupancy_o = r_occ;
    assign {out_meta_o, out_instruction_o} = w_bypass ? {in_meta_i, in_instruction_i}
                                                      : r_mem[r_rptr];

    always_ff @(posedge core_clock_i or negedge core_reset_i) begin
        if (!core_reset_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_occ <= r_occ + (AW + 1)'(w_wr) - (AW + 1)'(w_rd);
        end
    end

    always_ff @(posedge core_clock_i) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {in_meta_i, in_instruction_i};
        end
    end

`ifdef FETCH_BUNDLE_QUEUE_STATS_EN
    logic [31:0] r_full_cycles;
    logic [31:0] r_starve_cycles;

    always_ff @(posedge core_clock_i or negedge core_reset_i) begin
        if (!core_reset_i) begin
            r_full_cycles   <= '0;
            r_starve_cycles <= '0;
        end else begin
            if (in_vld_i && in_busy_o) begin
                r_full_cycles <= r_full_cycles + 32'd1;
            end
            if (!out_busy_i && !out_vld_o && !flush_i) begin
                r_starve_cycles <= r_starve_cycles + 32'd1;
            end
        end
    end

    assign full_cycles_o   = r_full_cycles;
    assign starve_cycles_o = r_starve_cycles;
`endif

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Directed bench for fetch_bundle_queue at DEPTH=4, FETCH_WORDS=2, PASSTHROUGH=1.
module tb_fetch_bundle_queue;

    localparam int DEPTH = 4;
    localparam int IW    = 64;
    localparam int MW    = 80;
    localparam int BW    = IW + MW;

    logic          core_clock_i = 1'b0;
    logic          core_reset_i = 1'b0;
    logic          flush_i      = 1'b0;
    logic          in_vld_i     = 1'b0;
    logic [IW-1:0] in_instruction_i = '0;
    logic [MW-1:0] in_meta_i    = '0;
    logic          in_busy_o;
    logic          out_vld_o;
    logic [IW-1:0] out_instruction_o;
    logic [MW-1:0] out_meta_o;
    logic          out_busy_i   = 1'b0;
    logic [2:0]    occupancy_o;
`ifdef FETCH_BUNDLE_QUEUE_STATS_EN
    logic [31:0]   full_cycles_o;
    logic [31:0]   starve_cycles_o;
`endif

    fetch_bundle_queue #(
        .FETCH_WORDS (2),
        .DEPTH       (DEPTH),
        .META_W      (MW),
        .PASSTHROUGH (1)
    ) dut (
        .core_clock_i      (core_clock_i),
        .core_reset_i      (core_reset_i),
        .flush_i           (flush_i),
        .in_vld_i          (in_vld_i),
        .in_instruction_i  (in_instruction_i),
        .in_meta_i         (in_meta_i),
        .in_busy_o         (in_busy_o),
        .out_vld_o         (out_vld_o),
        .out_instruction_o (out_instruction_o),
        .out_meta_o        (out_meta_o),
        .out_busy_i        (out_busy_i),
        .occupancy_o       (occupancy_o)
`ifdef FETCH_BUNDLE_QUEUE_STATS_EN
        ,
        .full_cycles_o     (full_cycles_o),
        .starve_cycles_o   (starve_cycles_o)
`endif
    );

    always #5 core_clock_i = ~core_clock_i;

    int n_vec = 0;
    int n_err = 0;
    logic [BW-1:0] q[$];

    task automatic check_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk(input int n);
        logic [31:0] k;
        k = 32'(n);
        return {16'hBEEF, 32'h0C0F_F000 + k, 32'h8000_0000 | k,
                32'h1000_0000 + k, 32'h2000_0000 + k};
    endfunction

    // One clock cycle: drive at posedge+1, sample combinational outputs at +3,
    // sample registered occupancy at next posedge+1. The queue q is the reference.
    task automatic step(input logic vld, input logic [BW-1:0] b, input logic obusy,
                        input logic fl, input string tag);
        logic          ev;
        logic          ebusy;
        logic          pop;
        logic          push;
        logic [BW-1:0] ed;
        in_vld_i = vld;
        {in_meta_i, in_instruction_i} = b;
        out_busy_i = obusy;
        flush_i = fl;
        #2;
        ebusy = (q.size() == DEPTH);
        ev    = !fl && (q.size() != 0 || vld);
        ed    = (q.size() != 0) ? q[0] : b;
        check_val({tag, ".vld"}, BW'(out_vld_o), BW'(ev));
        if (ev) check_val({tag, ".dat"}, {out_meta_o, out_instruction_o}, ed);
        check_val({tag, ".busy"}, BW'(in_busy_o), BW'(ebusy));
        pop  = ev && !obusy;
        push = vld && !ebusy && !fl;
        if (fl) begin
            q.delete();
        end else if (!(q.size() == 0 && push && pop)) begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(b);
        end
        @(posedge core_clock_i);
        #1;
        check_val({tag, ".occ"}, BW'(occupancy_o), BW'(q.size()));
        in_vld_i = 1'b0;
        flush_i  = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge core_clock_i);
        #1;
        check_val("rst.vld",  BW'(out_vld_o),   '0);
        check_val("rst.busy", BW'(in_busy_o),   '0);
        check_val("rst.occ",  BW'(occupancy_o), '0);
        core_reset_i = 1'b1;

        // Zero-latency bypass on the first edge after reset release
        step(1'b1, {80'h55, 64'h00000013_00000093}, 1'b0, 1'b0, "bypass");
        check_val("bypass.nostore", BW'(occupancy_o), '0);

        // Fill with consumer stalled: A..D, then E refused
        for (int i = 0; i < 4; i++) step(1'b1, mk(i), 1'b1, 1'b0, "fill");
        check_val("fill.occ4",  BW'(occupancy_o), BW'(4));
        check_val("fill.full",  BW'(in_busy_o),    BW'(1));
        step(1'b1, mk(4), 1'b1, 1'b0, "refuse");

        // Full with pop: A leaves, E still not taken
        step(1'b1, mk(4), 1'b0, 1'b0, "fullpop");
        check_val("fullpop.occ3",  BW'(occupancy_o), BW'(3));
        check_val("fullpop.nbusy", BW'(in_busy_o),    '0);

        // Flush at occupancy 3 with a concurrent push
        step(1'b1, mk(5), 1'b0, 1'b1, "flush");
        check_val("flush.occ0", BW'(occupancy_o), '0);
        step(1'b0, '0, 1'b0, 1'b0, "postflush");

        // Pointer wrap: prefill, alternating stalled push / pop, then steady push+pop
        step(1'b1, mk(30), 1'b1, 1'b0, "pre");
        step(1'b1, mk(31), 1'b1, 1'b0, "pre");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, mk(10 + i), 1'b1, 1'b0, "wrapin");
            step(1'b0, '0, 1'b0, 1'b0, "wrapout");
        end
        for (int i = 0; i < 3; i++) step(1'b1, mk(40 + i), 1'b0, 1'b0, "pushpop");
        check_val("pushpop.occ2", BW'(occupancy_o), BW'(2));
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, "drain");

        // Reset mid-stream at occupancy 2
        step(1'b1, mk(50), 1'b1, 1'b0, "prerst");
        step(1'b1, mk(51), 1'b1, 1'b0, "prerst");
        #2;
        core_reset_i = 1'b0;
        #1;
        q.delete();
        check_val("mrst.vld",  BW'(out_vld_o),   '0);
        check_val("mrst.occ",  BW'(occupancy_o), '0);
        check_val("mrst.busy", BW'(in_busy_o),   '0);
`ifdef FETCH_BUNDLE_QUEUE_STATS_EN
        check_val("mrst.fullcnt",   BW'(full_cycles_o),   '0);
        check_val("mrst.starvecnt", BW'(starve_cycles_o), '0);
`endif
        @(posedge core_clock_i);
        #1;
        core_reset_i = 1'b1;
        step(1'b1, mk(60), 1'b1, 1'b0, "firstpush");
        check_val("firstpush.occ1", BW'(occupancy_o), BW'(1));
        step(1'b0, '0, 1'b0, 1'b0, "lastpop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
